// File: rtl/inst_record_pkg.sv
// Shared types and helpers for the in-flight instruction record table and its
// downstream hazard checkers.
package inst_record_pkg;

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned MASK_W = 8;

   typedef struct packed {
      logic              vdValid;
      logic [REG_W-1:0]  vd;
      logic              vs1Valid;
      logic [REG_W-1:0]  vs1;
      logic [REG_W-1:0]  vs2;
      logic [IDX_W-1:0]  instIndex;
      logic              gather;
      logic              gather16;
      logic              onlyRead;
      logic [MASK_W-1:0] elementMask;
   } instRecordT;

   // Bit 2 is the wrap flag: a differing wrap flag inverts the low-bit ordering.
   function automatic logic idx_older(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
      return (a[1:0] < b[1:0]) ^ a[2] ^ b[2];
   endfunction

endpackage

// File: rtl/inst_record_age_select.sv
// Combinational reduction picking the oldest live instruction index.
module inst_record_age_select
   import inst_record_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
) (
   input  logic [ENTRIES-1:0]       valid,
   input  logic [IDX_W*ENTRIES-1:0] instIndexFlat,
   output logic [IDX_W-1:0]         oldestIndex
);

   logic found;
   logic qualifies;

   always_comb begin
      oldestIndex = '0;
      found       = 1'b0;
      qualifies   = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         qualifies = valid[i];
         for (int unsigned j = 0; j < ENTRIES; j++) begin
            if (j != i && valid[j] &&
                idx_older(instIndexFlat[IDX_W*j +: IDX_W], instIndexFlat[IDX_W*i +: IDX_W]))
               qualifies = 1'b0;
         end
         if (qualifies && !found) begin
            found       = 1'b1;
            oldestIndex = instIndexFlat[IDX_W*i +: IDX_W];
         end
      end
      // Inconsistent index sets can leave no candidate; fall back to the lowest live slot.
      if (!found) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && !found) begin
               found       = 1'b1;
               oldestIndex = instIndexFlat[IDX_W*i +: IDX_W];
            end
         end
      end
   end

endmodule

// File: rtl/inst_record_table.sv
// In-flight instruction record table: allocate on issue, update on vdDone/maskUpd,
// free on retire; all fields exported as flat registered vectors.
module inst_record_table
   import inst_record_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        alloc_valid,
   output logic                        alloc_ready,
   input  logic                        alloc_vd_valid,
   input  logic                        alloc_vs1_valid,
   input  logic                        alloc_gather,
   input  logic                        alloc_gather16,
   input  logic                        alloc_onlyRead,
   input  logic [4:0]                  alloc_vd,
   input  logic [4:0]                  alloc_vs1,
   input  logic [4:0]                  alloc_vs2,
   input  logic [IDX_W-1:0]            alloc_instIndex,
   input  logic [7:0]                  alloc_elementMask,
   input  logic                        retire_valid,
   input  logic [IDX_W-1:0]            retire_instIndex,
   input  logic                        vdDone_valid,
   input  logic [IDX_W-1:0]            vdDone_instIndex,
   input  logic                        maskUpd_valid,
   input  logic [IDX_W-1:0]            maskUpd_instIndex,
   input  logic [7:0]                  maskUpd_mask,
   output logic [ENTRIES-1:0]          rec_valid,
   output logic [ENTRIES-1:0]          rec_vd_valid,
   output logic [ENTRIES-1:0]          rec_vs1_valid,
   output logic [ENTRIES-1:0]          rec_gather,
   output logic [ENTRIES-1:0]          rec_gather16,
   output logic [ENTRIES-1:0]          rec_onlyRead,
   output logic [5*ENTRIES-1:0]        rec_vd,
   output logic [5*ENTRIES-1:0]        rec_vs1,
   output logic [5*ENTRIES-1:0]        rec_vs2,
   output logic [IDX_W*ENTRIES-1:0]    rec_instIndex,
   output logic [8*ENTRIES-1:0]        rec_elementMask,
   output logic [$clog2(ENTRIES+1)-1:0] count,
   output logic                        empty,
   output logic                        full,
   output logic                        oldest_valid,
   output logic [IDX_W-1:0]            oldest_instIndex,
   output logic                        retire_miss,
   output logic                        dup_error
);

   localparam int unsigned SLOT_W  = $clog2(ENTRIES);
   localparam int unsigned COUNT_W = $clog2(ENTRIES+1);

   instRecordT          recs [ENTRIES];
   logic [ENTRIES-1:0]  recValid;
   logic [COUNT_W-1:0]  countQ;
   logic                retireMissQ;
   logic                dupErrorQ;

   logic                retireHit, vdHit, maskHit, freeHit, dupHit, allocFire;
   logic [SLOT_W-1:0]   retireSlot, vdSlot, maskSlot, freeSlot;

   assign full        = (countQ == COUNT_W'(ENTRIES));
   assign empty       = (countQ == '0);
   assign alloc_ready = ~full;
   assign allocFire   = alloc_valid & ~full;

   // All lookups use pre-edge state: the lowest matching valid slot wins.
   always_comb begin
      retireHit = 1'b0; retireSlot = '0;
      vdHit     = 1'b0; vdSlot     = '0;
      maskHit   = 1'b0; maskSlot   = '0;
      freeHit   = 1'b0; freeSlot   = '0;
      dupHit    = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (retire_valid && !retireHit && recValid[i] && recs[i].instIndex == retire_instIndex) begin
            retireHit  = 1'b1;
            retireSlot = SLOT_W'(i);
         end
         if (vdDone_valid && !vdHit && recValid[i] && recs[i].instIndex == vdDone_instIndex) begin
            vdHit  = 1'b1;
            vdSlot = SLOT_W'(i);
         end
         if (maskUpd_valid && !maskHit && recValid[i] && recs[i].instIndex == maskUpd_instIndex) begin
            maskHit  = 1'b1;
            maskSlot = SLOT_W'(i);
         end
         if (!freeHit && !recValid[i]) begin
            freeHit  = 1'b1;
            freeSlot = SLOT_W'(i);
         end
      end
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (recValid[i] && recs[i].instIndex == alloc_instIndex &&
             !(retireHit && retireSlot == SLOT_W'(i)))
            dupHit = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) recs[i] <= '0;
         recValid    <= '0;
         countQ      <= '0;
         retireMissQ <= 1'b0;
         dupErrorQ   <= 1'b0;
      end else begin
         retireMissQ <= retire_valid & ~retireHit;
         if (retireHit)
            recValid[retireSlot] <= 1'b0;
         if (vdHit && !(retireHit && retireSlot == vdSlot))
            recs[vdSlot].vdValid <= 1'b0;
         if (maskHit && !(retireHit && retireSlot == maskSlot))
            recs[maskSlot].elementMask <= maskUpd_mask;
         if (allocFire) begin
            recValid[freeSlot] <= 1'b1;
            recs[freeSlot]     <= '{vdValid: alloc_vd_valid, vd: alloc_vd,
                                    vs1Valid: alloc_vs1_valid, vs1: alloc_vs1,
                                    vs2: alloc_vs2, instIndex: alloc_instIndex,
                                    gather: alloc_gather, gather16: alloc_gather16,
                                    onlyRead: alloc_onlyRead,
                                    elementMask: alloc_elementMask};
            if (dupHit)
               dupErrorQ <= 1'b1;
         end
         countQ <= countQ + COUNT_W'(allocFire) - COUNT_W'(retireHit);
      end
   end

   always_comb begin
      rec_vd_valid    = '0;
      rec_vs1_valid   = '0;
      rec_gather      = '0;
      rec_gather16    = '0;
      rec_onlyRead    = '0;
      rec_vd          = '0;
      rec_vs1         = '0;
      rec_vs2         = '0;
      rec_instIndex   = '0;
      rec_elementMask = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         rec_vd_valid[i]               = recs[i].vdValid;
         rec_vs1_valid[i]              = recs[i].vs1Valid;
         rec_gather[i]                 = recs[i].gather;
         rec_gather16[i]               = recs[i].gather16;
         rec_onlyRead[i]               = recs[i].onlyRead;
         rec_vd[5*i +: 5]              = recs[i].vd;
         rec_vs1[5*i +: 5]             = recs[i].vs1;
         rec_vs2[5*i +: 5]             = recs[i].vs2;
         rec_instIndex[IDX_W*i +: IDX_W] = recs[i].instIndex;
         rec_elementMask[8*i +: 8]     = recs[i].elementMask;
      end
   end

   assign rec_valid    = recValid;
   assign count        = countQ;
   assign oldest_valid = ~empty;
   assign retire_miss  = retireMissQ;
   assign dup_error    = dupErrorQ;

   inst_record_age_select #(.ENTRIES(ENTRIES)) ageSelect (
      .valid        (recValid),
      .instIndexFlat(rec_instIndex),
      .oldestIndex  (oldest_instIndex)
   );

endmodule

// File: tb/tb_inst_record_table.sv
// Directed self-checking bench for inst_record_table with hand-computed expectations.
module tb_inst_record_table;
   import inst_record_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        alloc_valid, alloc_ready;
   logic        alloc_vd_valid, alloc_vs1_valid, alloc_gather, alloc_gather16, alloc_onlyRead;
   logic [4:0]  alloc_vd, alloc_vs1, alloc_vs2;
   logic [2:0]  alloc_instIndex;
   logic [7:0]  alloc_elementMask;
   logic        retire_valid;
   logic [2:0]  retire_instIndex;
   logic        vdDone_valid;
   logic [2:0]  vdDone_instIndex;
   logic        maskUpd_valid;
   logic [2:0]  maskUpd_instIndex;
   logic [7:0]  maskUpd_mask;
   logic [3:0]  rec_valid, rec_vd_valid, rec_vs1_valid, rec_gather, rec_gather16, rec_onlyRead;
   logic [19:0] rec_vd, rec_vs1, rec_vs2;
   logic [11:0] rec_instIndex;
   logic [31:0] rec_elementMask;
   logic [2:0]  count;
   logic        empty, full, oldest_valid, retire_miss, dup_error;
   logic [2:0]  oldest_instIndex;

   int unsigned nChecked  = 0;
   int unsigned nMismatch = 0;

   always #5 clock = ~clock;

   inst_record_table #(.ENTRIES(4)) dut (
      .clock(clock), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_vd_valid(alloc_vd_valid), .alloc_vs1_valid(alloc_vs1_valid),
      .alloc_gather(alloc_gather), .alloc_gather16(alloc_gather16),
      .alloc_onlyRead(alloc_onlyRead),
      .alloc_vd(alloc_vd), .alloc_vs1(alloc_vs1), .alloc_vs2(alloc_vs2),
      .alloc_instIndex(alloc_instIndex), .alloc_elementMask(alloc_elementMask),
      .retire_valid(retire_valid), .retire_instIndex(retire_instIndex),
      .vdDone_valid(vdDone_valid), .vdDone_instIndex(vdDone_instIndex),
      .maskUpd_valid(maskUpd_valid), .maskUpd_instIndex(maskUpd_instIndex),
      .maskUpd_mask(maskUpd_mask),
      .rec_valid(rec_valid), .rec_vd_valid(rec_vd_valid), .rec_vs1_valid(rec_vs1_valid),
      .rec_gather(rec_gather), .rec_gather16(rec_gather16), .rec_onlyRead(rec_onlyRead),
      .rec_vd(rec_vd), .rec_vs1(rec_vs1), .rec_vs2(rec_vs2),
      .rec_instIndex(rec_instIndex), .rec_elementMask(rec_elementMask),
      .count(count), .empty(empty), .full(full),
      .oldest_valid(oldest_valid), .oldest_instIndex(oldest_instIndex),
      .retire_miss(retire_miss), .dup_error(dup_error)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecked++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b0;
      alloc_valid = 1'b0; alloc_vd_valid = 1'b0; alloc_vs1_valid = 1'b0;
      alloc_gather = 1'b0; alloc_gather16 = 1'b0; alloc_onlyRead = 1'b0;
      alloc_vd = '0; alloc_vs1 = '0; alloc_vs2 = '0;
      alloc_instIndex = '0; alloc_elementMask = '0;
      retire_valid = 1'b0; retire_instIndex = '0;
      vdDone_valid = 1'b0; vdDone_instIndex = '0;
      maskUpd_valid = 1'b0; maskUpd_instIndex = '0; maskUpd_mask = '0;
   endtask

   task automatic setAlloc(input logic [2:0] idx, input logic [7:0] mask);
      alloc_valid       = 1'b1;
      alloc_vd_valid    = 1'b1;
      alloc_vs1_valid   = 1'b1;
      alloc_instIndex   = idx;
      alloc_elementMask = mask;
      alloc_vd          = 5'd8 + 5'(idx);
      alloc_vs1         = 5'd16 + 5'(idx);
      alloc_vs2         = 5'd24 + 5'(idx);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic allocOne(input logic [2:0] idx, input logic [7:0] mask);
      idle(); setAlloc(idx, mask); tick(); idle();
   endtask

   task automatic retireOne(input logic [2:0] idx);
      idle(); retire_valid = 1'b1; retire_instIndex = idx; tick(); idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checkVal("rst_count",      32'(count), 32'd0);
      checkVal("rst_empty",      32'(empty), 32'd1);
      checkVal("rst_full",       32'(full), 32'd0);
      checkVal("rst_ready",      32'(alloc_ready), 32'd1);
      checkVal("rst_valid",      32'(rec_valid), 32'd0);
      checkVal("rst_mask",       rec_elementMask, 32'd0);
      checkVal("rst_oldestV",    32'(oldest_valid), 32'd0);
      checkVal("rst_oldestIdx",  32'(oldest_instIndex), 32'd0);
      checkVal("rst_miss",       32'(retire_miss), 32'd0);
      checkVal("rst_dup",        32'(dup_error), 32'd0);

      // Fill: idx 0..3 land in slots 0..3
      allocOne(3'd0, 8'h11); checkVal("fill_cnt1", 32'(count), 32'd1);
      allocOne(3'd1, 8'h22); checkVal("fill_cnt2", 32'(count), 32'd2);
      allocOne(3'd2, 8'hFF); checkVal("fill_cnt3", 32'(count), 32'd3);
      checkVal("fill_notfull", 32'(full), 32'd0);
      allocOne(3'd3, 8'h44); checkVal("fill_cnt4", 32'(count), 32'd4);
      checkVal("fill_full",   32'(full), 32'd1);
      checkVal("fill_ready",  32'(alloc_ready), 32'd0);
      checkVal("fill_valid",  32'(rec_valid), 32'hF);
      checkVal("fill_idx",    32'(rec_instIndex), 32'h688);
      checkVal("fill_vd",     32'(rec_vd), 32'({5'd11, 5'd10, 5'd9, 5'd8}));
      checkVal("fill_vs2",    32'(rec_vs2), 32'({5'd27, 5'd26, 5'd25, 5'd24}));
      checkVal("fill_mask",   rec_elementMask, 32'h44FF2211);
      checkVal("fill_oldest", 32'(oldest_instIndex), 32'd0);

      // Stall: request held while full
      allocOne(3'd5, 8'h99);
      checkVal("stall_cnt", 32'(count), 32'd4);
      checkVal("stall_idx", 32'(rec_instIndex), 32'h688);

      // Retire idx1 with simultaneous alloc idx4: alloc refused (full pre-edge)
      idle(); setAlloc(3'd4, 8'h55); retire_valid = 1'b1; retire_instIndex = 3'd1;
      tick();
      checkVal("rr_cnt",   32'(count), 32'd3);
      checkVal("rr_valid", 32'(rec_valid), 32'hD);
      checkVal("rr_ready", 32'(alloc_ready), 32'd1);
      checkVal("rr_miss",  32'(retire_miss), 32'd0);
      idle(); setAlloc(3'd4, 8'h55); tick(); idle();
      checkVal("refill_cnt",   32'(count), 32'd4);
      checkVal("refill_valid", 32'(rec_valid), 32'hF);
      checkVal("refill_idx",   32'(rec_instIndex), 32'h6A0);

      // vdDone + maskUpd on idx2 both apply
      vdDone_valid = 1'b1; vdDone_instIndex = 3'd2;
      maskUpd_valid = 1'b1; maskUpd_instIndex = 3'd2; maskUpd_mask = 8'h0F;
      tick(); idle();
      checkVal("upd_vdv",  32'(rec_vd_valid), 32'hB);
      checkVal("upd_mask", rec_elementMask, 32'h440F5511);

      // Retire wins: mask update on the retiring entry is dropped
      retire_valid = 1'b1; retire_instIndex = 3'd2;
      vdDone_valid = 1'b1; vdDone_instIndex = 3'd2;
      maskUpd_valid = 1'b1; maskUpd_instIndex = 3'd2; maskUpd_mask = 8'hA0;
      tick(); idle();
      checkVal("prio_valid", 32'(rec_valid), 32'hB);
      checkVal("prio_mask",  rec_elementMask, 32'h440F5511);
      checkVal("prio_idx",   32'(rec_instIndex), 32'h6A0);
      checkVal("prio_cnt",   32'(count), 32'd3);

      // Drain, then wrap ordering with 6,7,0
      retireOne(3'd0); retireOne(3'd4); retireOne(3'd3);
      checkVal("drain_empty", 32'(empty), 32'd1);
      allocOne(3'd6, 8'h01); allocOne(3'd7, 8'h02); allocOne(3'd0, 8'h03);
      checkVal("wrap_idx",     32'(rec_instIndex[8:0]), 32'({3'd0, 3'd7, 3'd6}));
      checkVal("wrap_oldest6", 32'(oldest_instIndex), 32'd6);
      checkVal("wrap_oldestV", 32'(oldest_valid), 32'd1);
      retireOne(3'd6); checkVal("wrap_oldest7", 32'(oldest_instIndex), 32'd7);
      retireOne(3'd7); checkVal("wrap_oldest0", 32'(oldest_instIndex), 32'd0);
      checkVal("wrap_valid", 32'(rec_valid), 32'h4);

      // Retire miss pulses exactly one cycle
      retireOne(3'd5);
      checkVal("miss_pulse", 32'(retire_miss), 32'd1);
      checkVal("miss_cnt",   32'(count), 32'd1);
      checkVal("miss_valid", 32'(rec_valid), 32'h4);
      tick();
      checkVal("miss_clear", 32'(retire_miss), 32'd0);

      // Duplicate index: accepted, sticky error, lowest slot matches
      allocOne(3'd3, 8'h30);
      checkVal("dup_first", 32'(dup_error), 32'd0);
      allocOne(3'd3, 8'h31);
      checkVal("dup_set", 32'(dup_error), 32'd1);
      checkVal("dup_cnt", 32'(count), 32'd3);
      tick();
      checkVal("dup_sticky", 32'(dup_error), 32'd1);
      retireOne(3'd3);
      checkVal("dup_retire_low", 32'(rec_valid), 32'h6);
      checkVal("dup_retire_cnt", 32'(count), 32'd2);

      // Reset with live entries and a pending alloc
      allocOne(3'd1, 8'h10);
      checkVal("prerst_cnt", 32'(count), 32'd3);
      idle(); setAlloc(3'd5, 8'h77); reset = 1'b1;
      tick(); idle();
      checkVal("mrst_cnt",   32'(count), 32'd0);
      checkVal("mrst_empty", 32'(empty), 32'd1);
      checkVal("mrst_valid", 32'(rec_valid), 32'd0);
      checkVal("mrst_dup",   32'(dup_error), 32'd0);
      checkVal("mrst_ready", 32'(alloc_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nMismatch);
      $finish;
   end

endmodule

// File: doc/inst_record_table.md
Name: inst_record_table

Overview:
- Holds the in-flight instruction records that the downstream per-record write-hazard checkers consume. One checker instance per entry.
- Allocates a record when an instruction issues, updates its write-done state and element mask as it progresses, and frees it on retire.
- Presents every entry's fields as flat, registered vectors, plus occupancy and the oldest live instruction index.

Parameters:
- ENTRIES, 4, number of record slots; range 2..8.
- IDX_W, 3, instruction index width; fixed; wrap-ordered (bit 2 is the wrap flag).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  issue request
- alloc_ready  out  1  a free slot exists
- alloc_vd_valid, alloc_vs1_valid, alloc_gather, alloc_gather16, alloc_onlyRead  in  1 each  record flags
- alloc_vd, alloc_vs1, alloc_vs2  in  5 each  register numbers
- alloc_instIndex  in  IDX_W  instruction index
- alloc_elementMask  in  8  initial element-group mask
- retire_valid  in  1  free the record with index retire_instIndex
- retire_instIndex  in  IDX_W
- vdDone_valid  in  1  writes finished for vdDone_instIndex
- vdDone_instIndex  in  IDX_W
- maskUpd_valid  in  1  replace elementMask of maskUpd_instIndex
- maskUpd_instIndex  in  IDX_W
- maskUpd_mask  in  8
- rec_valid  out  ENTRIES  per-slot valid
- rec_vd_valid, rec_vs1_valid, rec_gather, rec_gather16, rec_onlyRead  out  ENTRIES each  flattened, slot i at bit i
- rec_vd, rec_vs1, rec_vs2  out  5*ENTRIES each
- rec_instIndex  out  IDX_W*ENTRIES
- rec_elementMask  out  8*ENTRIES
- count  out  clog2(ENTRIES+1)  live entries
- empty, full  out  1 each
- oldest_valid  out  1  at least one live entry
- oldest_instIndex  out  IDX_W  oldest live index
- retire_miss  out  1  one-cycle pulse
- dup_error  out  1  sticky

Behaviour:
- Reset (synchronous, active-high):
  - All rec_* cleared to 0; count=0; empty=1; full=0; alloc_ready=1.
  - oldest_valid=0; oldest_instIndex=0; retire_miss=0; dup_error=0.
  - Reset asserted mid-operation discards every entry on that edge; all events that cycle are ignored.
- Allocation:
  - Handshake fires when alloc_valid & alloc_ready.
  - alloc_ready = ~full, computed from register state only; it never depends on alloc_valid.
  - Target slot is the lowest-numbered slot with rec_valid=0.
  - Fields are written at the edge; rec_* show the new entry from the next cycle (1-cycle latency).
- Retire:
  - A valid entry whose rec_instIndex == retire_instIndex has rec_valid cleared at the edge. All other fields keep stale values.
  - No match: retire_miss=1 for exactly the next cycle; no state change.
  - A slot freed this cycle is not reusable by an allocation in the same cycle. Free slots are evaluated from pre-edge state.
- vdDone: a matching valid entry has rec_vd_valid cleared. No match: silently ignored.
- maskUpd: a matching valid entry has rec_elementMask replaced by maskUpd_mask. No match: ignored.
- Same-cycle events on one entry:
  - retire takes priority; vdDone and maskUpd on that entry are dropped.
  - vdDone and maskUpd on the same entry both apply.
- Events naming an index being allocated in the same cycle do not match, because the entry is not yet present.
- Duplicate index:
  - Allocation whose index equals a live entry's index, where that entry is not retiring this cycle → dup_error sets (sticky until reset).
  - The allocation is still accepted.
  - Matching then uses the lowest-numbered matching slot.
- count / full / empty:
  - count is registered; next = count + accepted alloc − effective retire. Simultaneous alloc+retire leaves count unchanged.
  - full = (count==ENTRIES); empty = (count==0).
- Oldest:
  - Computed combinationally from registered entries.
  - a is older than b iff a[1:0] < b[1:0] XOR a[2] XOR b[2].
  - oldest = the live entry older than or equal to all others; ties go to the lowest slot.
  - oldest_valid = ~empty.

Decomposition:
- Shared package (inst_record_pkg):
  - IDX_W, the 5-bit register-number width, the 8-bit mask width.
  - A packed record typedef with fields vdValid, vd, vs1Valid, vs1, vs2, instIndex, gather, gather16, onlyRead, elementMask.
  - An `idx_older(a,b)` function shared with the hazard checker.
- Sub-module: inst_record_age_select, the combinational oldest-entry reduction over ENTRIES.

Test Plan:
- Fill and stall:
  - Reset, then allocate indices 0,1,2,3 back-to-back → count 1..4; full=1 after the 4th; alloc_ready=0.
  - A 5th request with valid high is held, not accepted.
- Retire and refill:
  - Full table; retire idx 1 while allocating idx 4 in the same cycle → alloc not accepted (full pre-edge); slot 1 freed; count=3.
  - Next cycle idx 4 lands in slot 1; count=4.
- Priority and mask update:
  - Entry idx 2 with mask 0xFF. Same cycle: vdDone=2 and maskUpd=2 with 0x0F → rec_vd_valid=0 and mask=0x0F next cycle.
  - Repeat with retire=2 added → entry invalid, other fields unchanged.
- Wrap ordering: live indices 6,7,0 (7→0 wraps) → oldest_instIndex=6. Retire 6 → 7. Retire 7 → 0.
- Retire miss: retire idx 5 with no match → retire_miss high one cycle; count unchanged. Allocating idx 3 twice → dup_error=1, sticky.
- Reset mid-operation: reset with 3 live entries plus alloc_valid asserted → count=0, empty=1, all rec_valid=0 next cycle; dup_error cleared.
